// File: rtl/axi_ohs_pkg.sv
// ---------------------------------------------------------------------------
// axi_ohs_pkg
// Shared constants for the AXI4-Lite register bank: bus data width, byte
// strobe width, the word-address LSB and the two response codes it returns.
// ---------------------------------------------------------------------------
package axi_ohs_pkg;

  localparam int DATA_W   = 32;
  localparam int STRB_W   = DATA_W / 8;
  localparam int ADDR_LSB = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_ohs_strb_merge.sv
// ---------------------------------------------------------------------------
// axi_ohs_strb_merge
// Byte-lane merge of a write into an existing register value.
//   prior_i  : current register contents
//   new_i    : write data
//   wstrb_i  : byte enables, lane k covers bits [k*8 +: 8]
//   merged_o : new_i on enabled lanes, prior_i elsewhere
// ---------------------------------------------------------------------------
module axi_ohs_strb_merge
  import axi_ohs_pkg::*;
(
  input  logic [DATA_W-1:0] prior_i,
  input  logic [DATA_W-1:0] new_i,
  input  logic [STRB_W-1:0] wstrb_i,
  output logic [DATA_W-1:0] merged_o
);

  always_comb begin
    merged_o = prior_i;
    for (int k = 0; k < STRB_W; k++) begin
      if (wstrb_i[k]) merged_o[k*8 +: 8] = new_i[k*8 +: 8];
    end
  end

endmodule

// File: rtl/axi_ohs_regbank.sv
// ---------------------------------------------------------------------------
// axi_ohs_regbank
// AXI4-Lite slave exposing NUM_REGS 32-bit registers. Slots flagged in
// RO_MASK are read-only and return the matching reg_in slice.
//   s_axi_aclk / s_axi_areset : clock, synchronous active-high reset
//   s_axi_aw* / s_axi_w* / s_axi_b* : write address, data, response channels
//   s_axi_ar* / s_axi_r*            : read address and data channels
//   reg_out      : stored register values, 32 bits per slot (0 on RO slots)
//   reg_in       : hardware values returned for RO slots
//   reg_wr_pulse : one-cycle strobe per successful register write
// ---------------------------------------------------------------------------
module axi_ohs_regbank
  import axi_ohs_pkg::*;
#(
  parameter int                  S_AXI_ADDR_WIDTH = 6,
  parameter int                  NUM_REGS         = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK          = '0
) (
  input  logic                         s_axi_aclk,
  input  logic                         s_axi_areset,
  input  logic [S_AXI_ADDR_WIDTH-1:0]  s_axi_awaddr,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [DATA_W-1:0]            s_axi_wdata,
  input  logic [STRB_W-1:0]            s_axi_wstrb,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [S_AXI_ADDR_WIDTH-1:0]  s_axi_araddr,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [DATA_W-1:0]            s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  input  logic [NUM_REGS*DATA_W-1:0]   reg_in,
  output logic [NUM_REGS-1:0]          reg_wr_pulse
);

  localparam int IDX_W = S_AXI_ADDR_WIDTH - ADDR_LSB;

  logic              aw_held_q, aw_held_d;
  logic [IDX_W-1:0]  aw_idx_q,  aw_idx_d;
  logic              w_held_q,  w_held_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [STRB_W-1:0] wstrb_q,   wstrb_d;
  logic              bvalid_q,  bvalid_d;
  logic [1:0]        bresp_q,   bresp_d;
  logic              rvalid_q,  rvalid_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic [1:0]        rresp_q,   rresp_d;
  logic [NUM_REGS-1:0] pulse_q, pulse_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic              aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]  ar_idx;
  logic [NUM_REGS-1:0] wr_sel, rd_sel;
  logic              wr_ok, rd_ok, rd_ro;
  logic [DATA_W-1:0] wr_prior, wr_merged, rd_val;
  logic              unused_ok;

  assign aw_hs  = s_axi_awvalid && !aw_held_q;
  assign w_hs   = s_axi_wvalid  && !w_held_q;
  assign ar_hs  = s_axi_arvalid && !rvalid_q;
  assign ar_idx = s_axi_araddr[S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  // A full address/data pair retires only when the response slot is free,
  // or is being freed on this same edge.
  assign commit = aw_held_q && w_held_q && (!bvalid_q || s_axi_bready);

  // Byte offsets are irrelevant to a word bank; writable slots never read reg_in.
  assign unused_ok = ^{s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0], reg_in};

  // Index decode; an all-zero select vector means the index is out of range.
  always_comb begin
    wr_sel   = '0;
    rd_sel   = '0;
    wr_prior = '0;
    rd_val   = '0;
    rd_ro    = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = (aw_idx_q == IDX_W'(i));
      rd_sel[i] = (ar_idx == IDX_W'(i));
      if (wr_sel[i]) wr_prior = regs_q[i];
      if (rd_sel[i]) begin
        rd_val = RO_MASK[i] ? reg_in[i*DATA_W +: DATA_W] : regs_q[i];
        rd_ro  = RO_MASK[i];
      end
    end
    wr_ok = |(wr_sel & ~RO_MASK);
    rd_ok = |rd_sel;
  end

  axi_ohs_strb_merge u_merge (
    .prior_i  (wr_prior),
    .new_i    (wdata_q),
    .wstrb_i  (wstrb_q),
    .merged_o (wr_merged)
  );

  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    pulse_d   = '0;
    regs_d    = regs_q;

    // commit needs both holds full and a handshake needs its hold empty,
    // so the clears below never collide with a same-edge capture.
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s_axi_awaddr[S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi_wdata;
      wstrb_d  = s_axi_wstrb;
    end

    if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (wr_ok) begin
        pulse_d = wr_sel;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (wr_sel[i]) regs_d[i] = wr_merged;
        end
      end
    end

    // Reads sample regs_q, so a same-edge write commit is not yet visible.
    if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_ok ? rd_val : '0;
      rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
    if (ar_hs && rd_ro) rresp_d = RESP_OKAY;
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      pulse_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      pulse_q   <= pulse_d;
      regs_q    <= regs_d;
    end
  end

  assign s_axi_awready = !aw_held_q;
  assign s_axi_wready  = !w_held_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = !rvalid_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign reg_wr_pulse  = pulse_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_W +: DATA_W] = RO_MASK[g] ? '0 : regs_q[g];
  end

endmodule

// File: tb/tb_axi_ohs_regbank.sv
// ---------------------------------------------------------------------------
// tb_axi_ohs_regbank
// Bench for axi_ohs_regbank (8 registers, slot 2 read-only): directed
// latency/corner sequences, a vector table, then randomized traffic compared
// against a word-array model of the register bank.
// ---------------------------------------------------------------------------
module tb_axi_ohs_regbank;

  localparam int AW = 6;
  localparam int NR = 8;
  localparam logic [NR-1:0] RO = 8'h04;

  logic             clk;
  logic             s_axi_areset;
  logic [AW-1:0]    s_axi_awaddr;
  logic             s_axi_awvalid;
  logic             s_axi_awready;
  logic [31:0]      s_axi_wdata;
  logic [3:0]       s_axi_wstrb;
  logic             s_axi_wvalid;
  logic             s_axi_wready;
  logic [1:0]       s_axi_bresp;
  logic             s_axi_bvalid;
  logic             s_axi_bready;
  logic [AW-1:0]    s_axi_araddr;
  logic             s_axi_arvalid;
  logic             s_axi_arready;
  logic [31:0]      s_axi_rdata;
  logic [1:0]       s_axi_rresp;
  logic             s_axi_rvalid;
  logic             s_axi_rready;
  logic [NR*32-1:0] reg_out;
  logic [NR*32-1:0] reg_in;
  logic [NR-1:0]    reg_wr_pulse;

  axi_ohs_regbank #(
    .S_AXI_ADDR_WIDTH (AW),
    .NUM_REGS         (NR),
    .RO_MASK          (RO)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (s_axi_areset),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .reg_out       (reg_out),
    .reg_in        (reg_in),
    .reg_wr_pulse  (reg_wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Cumulative count of pulse cycles seen per register.
  int pulse_cnt [NR];
  initial for (int i = 0; i < NR; i++) pulse_cnt[i] = 0;
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) if (reg_wr_pulse[i]) pulse_cnt[i] = pulse_cnt[i] + 1;
  end

  // ---------------- reference model ----------------
  logic [31:0] model_regs [NR];
  logic [31:0] hw_in      [NR];

  function automatic logic [1:0] model_write(input logic [5:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    int idx;
    logic [31:0] mask;
    idx = int'(addr) / 4;
    if (idx >= NR || RO[idx]) return 2'b10;
    mask = 32'h0;
    for (int k = 0; k < 4; k++) if (strb[k]) mask = mask | (32'hFF << (8 * k));
    model_regs[idx] = (model_regs[idx] & ~mask) | (data & mask);
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(input logic [5:0] addr);
    int idx;
    idx = int'(addr) / 4;
    if (idx >= NR) return {2'b10, 32'h0};
    if (RO[idx]) return {2'b00, hw_in[idx]};
    return {2'b00, model_regs[idx]};
  endfunction

  function automatic logic [NR*32-1:0] model_regout();
    logic [NR*32-1:0] v;
    v = '0;
    for (int i = 0; i < NR; i++) if (!RO[i]) v[i*32 +: 32] = model_regs[i];
    return v;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_axi_areset  = 1'b1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_arvalid = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_rready  = 1'b0;
    repeat (2) tick();
    s_axi_areset = 1'b0;
    for (int i = 0; i < NR; i++) model_regs[i] = 32'h0;
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input bit rnd_b,
                           output logic [1:0] resp, output bit to);
    bit aw_done, w_done, hs_aw, hs_w, hs;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0; to = 0; resp = 2'bxx;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb; s_axi_bready = 1'b0;
    while (!(aw_done && w_done) && !to) begin
      s_axi_awvalid = !aw_done && (cyc >= aw_dly);
      s_axi_wvalid  = !w_done && (cyc >= w_dly);
      hs_aw = s_axi_awvalid && s_axi_awready;
      hs_w  = s_axi_wvalid && s_axi_wready;
      tick();
      if (hs_aw) aw_done = 1;
      if (hs_w)  w_done  = 1;
      cyc++;
      if (cyc > 60) to = 1;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    cyc = 0;
    while (!to) begin
      s_axi_bready = rnd_b ? ($urandom_range(0, 1) != 0) : 1'b1;
      hs = s_axi_bvalid && s_axi_bready;
      if (hs) resp = s_axi_bresp;
      tick();
      s_axi_bready = 1'b0;
      if (hs) break;
      cyc++;
      if (cyc > 60) to = 1;
    end
  endtask

  task automatic axi_read(input logic [5:0] addr, input bit rnd_r,
                          output logic [31:0] data, output logic [1:0] resp, output bit to);
    bit hs;
    int cyc;
    cyc = 0; to = 0; data = 'x; resp = 'x;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    while (!to) begin
      hs = s_axi_arvalid && s_axi_arready;
      tick();
      if (hs) break;
      cyc++;
      if (cyc > 60) to = 1;
    end
    s_axi_arvalid = 1'b0;
    cyc = 0;
    while (!to) begin
      s_axi_rready = rnd_r ? ($urandom_range(0, 1) != 0) : 1'b1;
      hs = s_axi_rvalid && s_axi_rready;
      if (hs) begin data = s_axi_rdata; resp = s_axi_rresp; end
      tick();
      s_axi_rready = 1'b0;
      if (hs) break;
      cyc++;
      if (cyc > 60) to = 1;
    end
  endtask

  task automatic do_write(input string tag, input logic [5:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly, input bit rnd_b);
    int snap [NR];
    logic [1:0] exp_resp, resp;
    logic [NR-1:0] exp_p, got_p;
    bit to;
    int idx;
    for (int i = 0; i < NR; i++) snap[i] = pulse_cnt[i];
    idx = int'(addr) / 4;
    exp_resp = model_write(addr, data, strb);
    axi_write(addr, data, strb, aw_dly, w_dly, rnd_b, resp, to);
    check({tag, "_wr_timeout"}, to, 0);
    check({tag, "_bresp"}, resp, exp_resp);
    exp_p = (exp_resp == 2'b00) ? NR'(1) << idx : '0;
    got_p = '0;
    for (int i = 0; i < NR; i++) begin
      if (pulse_cnt[i] - snap[i] == 1) got_p[i] = 1'b1;
      else if (pulse_cnt[i] != snap[i]) got_p = ~exp_p;
    end
    check({tag, "_pulse"}, got_p, exp_p);
    check({tag, "_reg_out"}, reg_out, model_regout());
  endtask

  task automatic do_read(input string tag, input logic [5:0] addr, input bit rnd_r);
    logic [31:0] d;
    logic [1:0] r;
    logic [33:0] e;
    bit to;
    e = model_read(addr);
    axi_read(addr, rnd_r, d, r, to);
    check({tag, "_rd_timeout"}, to, 0);
    check({tag, "_rdata"}, d, e[31:0]);
    check({tag, "_rresp"}, r, e[33:32]);
  endtask

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt [12];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [1:0]  resp;
    logic [31:0] rd;
    bit          to, stable;
    int          bcnt;

    vt[0]  = '{1'b1, 6'h10, 32'h01020304, 4'hF, 2'b00, 32'h0};
    vt[1]  = '{1'b0, 6'h10, 32'h0,        4'h0, 2'b00, 32'h01020304};
    vt[2]  = '{1'b1, 6'h11, 32'hFFFFFFFF, 4'h8, 2'b00, 32'h0};
    vt[3]  = '{1'b0, 6'h13, 32'h0,        4'h0, 2'b00, 32'hFF020304};
    vt[4]  = '{1'b1, 6'h20, 32'hCAFEF00D, 4'hF, 2'b10, 32'h0};
    vt[5]  = '{1'b0, 6'h20, 32'h0,        4'h0, 2'b10, 32'h0};
    vt[6]  = '{1'b1, 6'h08, 32'h99999999, 4'hF, 2'b10, 32'h0};
    vt[7]  = '{1'b0, 6'h08, 32'h0,        4'h0, 2'b00, 32'h12345678};
    vt[8]  = '{1'b1, 6'h1C, 32'h55AA55AA, 4'h3, 2'b00, 32'h0};
    vt[9]  = '{1'b0, 6'h1C, 32'h0,        4'h0, 2'b00, 32'h000055AA};
    vt[10] = '{1'b1, 6'h1C, 32'h12345678, 4'h0, 2'b00, 32'h0};
    vt[11] = '{1'b0, 6'h1D, 32'h0,        4'h0, 2'b00, 32'h000055AA};

    for (int i = 0; i < NR; i++) hw_in[i] = 32'hC0DE0000 | 32'(i);
    hw_in[2] = 32'h12345678;
    for (int i = 0; i < NR; i++) reg_in[i*32 +: 32] = hw_in[i];
    s_axi_awaddr = '0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_araddr = '0;

    do_reset();
    check("rst_awready", s_axi_awready, 1);
    check("rst_wready",  s_axi_wready, 1);
    check("rst_arready", s_axi_arready, 1);
    check("rst_bvalid",  s_axi_bvalid, 0);
    check("rst_rvalid",  s_axi_rvalid, 0);
    check("rst_rdata",   s_axi_rdata, 0);
    check("rst_reg_out", reg_out, 0);
    check("rst_pulse",   reg_wr_pulse, 0);

    // Single-cycle AW+W: response and pulse two edges after valids go up.
    s_axi_awaddr = 6'h04; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("lat_bvalid_early", s_axi_bvalid, 0);
    tick();
    check("lat_bvalid", s_axi_bvalid, 1);
    check("lat_bresp", s_axi_bresp, 2'b00);
    check("lat_reg1", reg_out[63:32], 32'hDEADBEEF);
    check("lat_pulse", reg_wr_pulse, 8'h02);
    tick();
    check("lat_pulse_off", reg_wr_pulse, 8'h00);
    check("lat_bvalid_off", s_axi_bvalid, 0);
    s_axi_bready = 1'b0;
    void'(model_write(6'h04, 32'hDEADBEEF, 4'hF));

    // W arrives three cycles ahead of AW, partial strobe.
    do_write("pre0", 6'h00, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    s_axi_wdata = 32'h11223344; s_axi_wstrb = 4'b0101; s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    check("early_w_wready", s_axi_wready, 0);
    check("early_w_awready", s_axi_awready, 1);
    repeat (2) tick();
    check("early_w_no_bvalid", s_axi_bvalid, 0);
    s_axi_awaddr = 6'h00; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    bcnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (s_axi_bvalid) bcnt++;
      tick();
    end
    s_axi_bready = 1'b0;
    check("early_w_bcount", bcnt, 1);
    check("early_w_reg0", reg_out[31:0], 32'hAA22CC44);
    void'(model_write(6'h00, 32'h11223344, 4'b0101));

    // Read-only slot.
    do_write("ro_wr", 6'h08, 32'hFFFF0000, 4'hF, 0, 0, 0);
    do_read("ro_rd", 6'h08, 0);

    // Read and write commit to the same register on one edge.
    do_write("pre5", 6'h14, 32'h00000005, 4'hF, 0, 0, 0);
    s_axi_awaddr = 6'h14; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h00000077; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_araddr = 6'h14; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    tick();
    s_axi_arvalid = 1'b0;
    check("rw_same_rvalid", s_axi_rvalid, 1);
    check("rw_same_rdata", s_axi_rdata, 32'h00000005);
    check("rw_same_reg5", reg_out[191:160], 32'h00000077);
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0; s_axi_bready = 1'b0;
    void'(model_write(6'h14, 32'h00000077, 4'hF));

    // Out-of-range read with rready held low.
    s_axi_araddr = 6'h3C; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    tick();
    s_axi_arvalid = 1'b0;
    check("oor_rvalid", s_axi_rvalid, 1);
    check("oor_rdata", s_axi_rdata, 0);
    check("oor_rresp", s_axi_rresp, 2'b10);
    check("oor_arready", s_axi_arready, 0);
    stable = 1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (!(s_axi_rvalid && s_axi_rdata == 32'h0 && s_axi_rresp == 2'b10 && !s_axi_arready))
        stable = 0;
    end
    check("oor_hold", stable, 1);
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    check("oor_rvalid_off", s_axi_rvalid, 0);
    check("oor_arready_on", s_axi_arready, 1);

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      if (vt[i].wr) begin
        axi_write(vt[i].addr, vt[i].data, vt[i].strb, 0, 0, 0, resp, to);
        void'(model_write(vt[i].addr, vt[i].data, vt[i].strb));
        check($sformatf("vec%0d_timeout", i), to, 0);
        check($sformatf("vec%0d_bresp", i), resp, vt[i].exp_resp);
      end else begin
        axi_read(vt[i].addr, 0, rd, resp, to);
        check($sformatf("vec%0d_timeout", i), to, 0);
        check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
        check($sformatf("vec%0d_rresp", i), resp, vt[i].exp_resp);
      end
    end

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      logic [5:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      a = 6'($urandom_range(0, 63));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 6)
        do_write($sformatf("rnd%0d", t), a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), 1);
      else
        do_read($sformatf("rnd%0d", t), a, 1);
    end
    check("rnd_final_reg_out", reg_out, model_regout());

    // Back-pressured response with a second write queued.
    s_axi_bready = 1'b0;
    s_axi_awaddr = 6'h0C; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h33333333; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    tick();
    check("bp_first_bvalid", s_axi_bvalid, 1);
    s_axi_awvalid = 1'b1; s_axi_wdata = 32'h44444444; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("bp_awready", s_axi_awready, 0);
    check("bp_wready", s_axi_wready, 0);
    repeat (3) tick();
    check("bp_bvalid_hold", s_axi_bvalid, 1);
    check("bp_no_commit", reg_out[127:96], 32'h33333333);
    check("bp_awready_hold", s_axi_awready, 0);
    s_axi_bready = 1'b1;
    tick();
    check("bp_second_commit", reg_out[127:96], 32'h44444444);
    check("bp_second_bvalid", s_axi_bvalid, 1);
    check("bp_holds_free", {s_axi_awready, s_axi_wready}, 2'b11);
    tick();
    s_axi_bready = 1'b0;
    check("bp_bvalid_done", s_axi_bvalid, 0);
    void'(model_write(6'h0C, 32'h44444444, 4'hF));

    // Reset while a write waits behind an unaccepted response.
    s_axi_awvalid = 1'b1; s_axi_wdata = 32'h55555555; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    tick();
    s_axi_awvalid = 1'b1; s_axi_wdata = 32'h66666666; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("rstmid_pending", reg_out[127:96], 32'h55555555);
    do_reset();
    check("rstmid_bvalid", s_axi_bvalid, 0);
    check("rstmid_awready", s_axi_awready, 1);
    check("rstmid_wready", s_axi_wready, 1);
    s_axi_bready = 1'b1;
    repeat (4) tick();
    s_axi_bready = 1'b0;
    check("rstmid_no_commit", reg_out, model_regout());
    check("rstmid_bvalid_after", s_axi_bvalid, 0);
    do_read("rstmid_rd", 6'h0C, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_ohs_regbank.md
AXI_OHS_REGBANK -- requirements
Module: axi_ohs_regbank

Interface
REQ-001 Parameter S_AXI_ADDR_WIDTH, default 6, SHALL be the byte-address width; word index = addr[S_AXI_ADDR_WIDTH-1:2].
REQ-002 Parameter NUM_REGS, default 8, SHALL be the register count, 1..2^(S_AXI_ADDR_WIDTH-2).
REQ-003 Parameter RO_MASK, default 0, NUM_REGS bits; bit i set SHALL make register i read-only, sourced from reg_in.
REQ-004 Data width SHALL be fixed at 32 bits; strobe width 4.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 s_axi_aclk  in  1  clock.
REQ-007 s_axi_areset  in  1  synchronous active-high reset.
REQ-008 s_axi_awaddr/awvalid/awready, s_axi_wdata/wstrb/wvalid/wready, s_axi_bresp/bvalid/bready SHALL form a standard AXI4-Lite write slave; awaddr is S_AXI_ADDR_WIDTH bits, wdata 32, wstrb 4, bresp 2.
REQ-009 s_axi_araddr/arvalid/arready and s_axi_rdata/rresp/rvalid/rready SHALL form a standard AXI4-Lite read slave; araddr is S_AXI_ADDR_WIDTH bits, rdata 32, rresp 2.
REQ-010 reg_out  out  NUM_REGS*32  stored value of register i at [i*32 +: 32]; 0 for RO slots.
REQ-011 reg_in  in  NUM_REGS*32  hardware value returned for RO register i.
REQ-012 reg_wr_pulse  out  NUM_REGS  one-cycle strobe per successful write.

Function
REQ-013 AW and W SHALL be accepted independently: awready = no address held; wready = no data held; each held in a holding register after handshake.
REQ-014 Write commit SHALL occur on the edge where address and data are both held and (!bvalid || bready); that edge updates the register, sets bvalid, clears both holds.
REQ-015 Minimum write latency: AW+W handshake at edge N, commit at edge N+1, bvalid high after N+1.
REQ-016 Byte lanes with wstrb[k]=0 SHALL keep prior register bits [k*8 +: 8].
REQ-017 bresp SHALL be 2'b00 for an in-range RW index; 2'b10 (SLVERR) for index >= NUM_REGS or an RO index, with no register change and no pulse.
REQ-018 reg_wr_pulse[i] SHALL be high exactly the cycle after commit (coincident with bvalid rising).
REQ-019 bvalid and bresp SHALL remain stable until bready is sampled high.
REQ-020 arready SHALL equal !rvalid; on the AR handshake edge rdata/rresp SHALL be captured and rvalid set.
REQ-021 rdata SHALL be the stored value for an RW index, reg_in slice for an RO index, 0 with SLVERR for index >= NUM_REGS.
REQ-022 rvalid/rdata/rresp SHALL hold while rvalid && !rready; rvalid clears on the rready edge.
REQ-023 A read and write commit to the same register on the same edge SHALL return the pre-write value.
REQ-024 Address bits [1:0] SHALL be ignored.

Reset
REQ-025 Reset SHALL zero all registers, holds, bvalid, rvalid, rdata, bresp, rresp, reg_wr_pulse; awready/wready high and arready high the cycle after reset deasserts.
REQ-026 Reset mid-transaction SHALL discard held address/data and pending responses, with no register update.

Structure
REQ-027 Package axi_ohs_pkg SHALL hold the data width (32), ADDR_LSB (2), RESP_OKAY (2'b00) and RESP_SLVERR (2'b10).
REQ-028 Byte-strobe merge SHALL be a sub-module axi_ohs_strb_merge (prior, new, wstrb -> merged).

Verification
REQ-029 Write 0xDEADBEEF to 0x04 with wstrb=4'hF, AW and W in the same cycle -> bvalid two edges later, bresp=00, reg_out[63:32]=0xDEADBEEF, reg_wr_pulse=8'h02 for one cycle.
REQ-030 W three cycles before AW; wstrb=4'b0101, data 0x11223344 onto 0xAABBCCDD at reg 0 -> reg 0 = 0xAA22CC44, single bvalid.
REQ-031 RO_MASK=8'h04, reg_in slice 2=0x12345678: write reg 2 -> SLVERR, no pulse; read 0x08 -> 0x12345678, OKAY.
REQ-032 Read address 0x3C with NUM_REGS=8 -> rdata=0, rresp=10; rready held low 5 cycles -> rvalid, rdata stable, arready low.
REQ-033 bready low with a second AW+W queued -> both holds full, awready/wready low, no commit until bready high; reset asserted mid-wait -> bvalid=0, register unchanged.
